// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator.
// All channels share one free-running time base: a blink counter, a PWM
// counter and a triangle-wave duty value. Each channel picks OFF, ON, BLINK
// or BREATHE at runtime. Odd channels may run antiphase so that a default
// two-LED board looks exactly like the old single-counter blinker.
// STEP_SHIFT must be smaller than CNT_WIDTH, because the duty step is
// derived from the low bits of the blink counter.

module led_pattern_gen #(
    parameter int NUM_LEDS   = 2,
    parameter int CNT_WIDTH  = 25,
    parameter int PWM_WIDTH  = 8,
    parameter int STEP_SHIFT = 16,
    parameter bit ALT_PHASE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*NUM_LEDS-1:0] mode_in,
    input  logic                  mode_load,
    output logic [NUM_LEDS-1:0]   led
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
    localparam logic [PWM_WIDTH-1:0]  PWM_ONE  = 1;
    localparam logic [PWM_WIDTH-1:0]  DUTY_MAX = '1;
    localparam logic [2*NUM_LEDS-1:0] MODE_RST = {NUM_LEDS{MODE_BLINK}};

    logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
    logic [PWM_WIDTH-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [PWM_WIDTH-1:0]  duty_q,    duty_d;
    dir_e                  dir_q,     dir_d;
    logic [2*NUM_LEDS-1:0] mode_q,    mode_d;
    logic [NUM_LEDS-1:0]   led_q,     led_d;

    logic                  step;
    logic                  ph;
    logic [PWM_WIDTH-1:0]  duty_ch;

    // The duty value advances once every 2^STEP_SHIFT clocks.
    assign step = &cnt_q[STEP_SHIFT-1:0];

    // Shared time base and mode capture; a mode change never disturbs the counters.
    always_comb begin
        // NOTE: every signal written here gets a value on every path; a missing default would infer a latch.
        cnt_d     = cnt_q + CNT_ONE;
        pwm_cnt_d = pwm_cnt_q + PWM_ONE;
        mode_d    = mode_load ? mode_in : mode_q;
    end

    // Registers for the time base, the channel modes and the LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q     <= '0;
            pwm_cnt_q <= '0;
            mode_q    <= MODE_RST;
            led_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            mode_q    <= mode_d;
            led_q     <= led_d;
        end
    end

    // Duty FSM state register: direction plus the current duty value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q  <= DIR_UP;
            duty_q <= '0;
        end else begin
            dir_q  <= dir_d;
            duty_q <= duty_d;
        end
    end

    // Duty FSM next state: triangle wave that bounces off MAX and 0, holding each endpoint one step.
    always_comb begin
        dir_d  = dir_q;
        duty_d = duty_q;
        if (step) begin
            unique case (dir_q)
                DIR_UP: begin
                    if (duty_q == DUTY_MAX) begin
                        duty_d = DUTY_MAX - PWM_ONE;
                        dir_d  = DIR_DOWN;
                    end else begin
                        duty_d = duty_q + PWM_ONE;
                    end
                end
                DIR_DOWN: begin
                    if (duty_q == '0) begin
                        duty_d = PWM_ONE;
                        dir_d  = DIR_UP;
                    end else begin
                        duty_d = duty_q - PWM_ONE;
                    end
                end
                default: begin
                    dir_d  = DIR_UP;
                    duty_d = '0;
                end
            endcase
        end
    end

    // Output decode: per-channel LED level from its mode and the shared time base.
    always_comb begin
        led_d   = '0;
        ph      = 1'b0;
        duty_ch = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            ph      = ALT_PHASE && ((i % 2) == 1);
            duty_ch = ph ? ~duty_q : duty_q;
            unique case (mode_e'(mode_q[2*i +: 2]))
                MODE_OFF:     led_d[i] = 1'b0;
                MODE_ON:      led_d[i] = 1'b1;
                MODE_BLINK:   led_d[i] = cnt_q[CNT_WIDTH-1] ^ ph;
                MODE_BREATHE: led_d[i] = (pwm_cnt_q < duty_ch);
                default:      led_d[i] = 1'b0;
            endcase
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed bench for led_pattern_gen with a small
// parameter set (CNT_WIDTH=4, PWM_WIDTH=3, STEP_SHIFT=2, NUM_LEDS=2).
// A behavioural model counts clock edges since reset and derives the
// expected time base and triangle-wave duty arithmetically; each expected
// LED value is queued before its clock edge and popped after it.

module tb_led_pattern_gen;

    localparam int NUM_LEDS   = 2;
    localparam int CNT_WIDTH  = 4;
    localparam int PWM_WIDTH  = 3;
    localparam int STEP_SHIFT = 2;
    localparam int DMAX       = 7;
    localparam int TRI_PERIOD = 2 * DMAX;

    logic                  clk;
    logic                  rst_n;
    logic [2*NUM_LEDS-1:0] mode_in;
    logic                  mode_load;
    logic [NUM_LEDS-1:0]   led;

    int                    n_tests;
    int                    n_fail;
    int                    model_n;
    logic [3:0]            model_mode;
    logic [1:0]            exp_q[$];

    led_pattern_gen #(
        .NUM_LEDS  (NUM_LEDS),
        .CNT_WIDTH (CNT_WIDTH),
        .PWM_WIDTH (PWM_WIDTH),
        .STEP_SHIFT(STEP_SHIFT),
        .ALT_PHASE (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_in  (mode_in),
        .mode_load(mode_load),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Duty after k steps: 0,1,..,7,6,..,1 then repeating from 0.
    function automatic int exp_duty(input int k);
        int r;
        r = k % TRI_PERIOD;
        return (r <= DMAX) ? r : TRI_PERIOD - r;
    endfunction

    // Direction after k steps: 0 = up, 1 = down; the 0 endpoint is reached while still going down.
    function automatic int exp_dir(input int k);
        int r;
        r = k % TRI_PERIOD;
        if (k == 0)               return 0;
        if (r >= 1 && r <= DMAX)  return 0;
        return 1;
    endfunction

    // Expected LED level after the next edge, from the model state before it.
    function automatic logic [1:0] model_led();
        logic [1:0] res;
        int         cnt;
        int         pwm;
        int         d;
        int         di;
        int         ph;
        logic [1:0] m;
        cnt = model_n % 16;
        pwm = model_n % 8;
        d   = exp_duty(model_n / 4);
        res = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ph = i;
            m  = (i == 0) ? model_mode[1:0] : model_mode[3:2];
            di = (ph == 1) ? (DMAX - d) : d;
            case (m)
                2'b00: res[i] = 1'b0;
                2'b01: res[i] = 1'b1;
                2'b10: res[i] = ((cnt >= 8) ? 1'b1 : 1'b0) ^ ph[0];
                default: res[i] = (pwm < di);
            endcase
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: queue the expectation, advance the model at the edge, compare 1 ns later.
    task automatic tick();
        logic [1:0] e;
        exp_q.push_back(model_led());
        @(posedge clk);
        model_n++;
        if (mode_load) model_mode = mode_in;
        #1;
        e = exp_q.pop_front();
        check("led",  32'(led), 32'(e));
        check("duty", 32'(dut.duty_q), 32'(exp_duty(model_n / 4)));
        check("dir",  32'(dut.dir_q), 32'(exp_dir(model_n / 4)));
        check("cnt",  32'(dut.cnt_q), 32'(model_n % 16));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        model_n    = 0;
        model_mode = 4'b1010;
        rst_n      = 1'b0;
        mode_in    = 4'b0000;
        mode_load  = 1'b0;

        // Reset state, then release between edges.
        #12;
        check("reset_led",  32'(led), 32'd0);
        check("reset_mode", 32'(dut.mode_q), 32'hA);
        #10;
        rst_n = 1'b1;
        check("pre_edge_led", 32'(led), 32'd0);

        // Legacy blinker: two full blink periods.
        ticks(34);

        // ch1 ON, ch0 OFF; held after the strobe drops.
        mode_in   = 4'b0100;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        mode_in   = 4'b1111;
        ticks(10);
        check("on_off_led", 32'(led), 32'h2);

        // Both BREATHE across two full triangle periods.
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        ticks(2 * TRI_PERIOD * 4 + 6);

        // Mode load in the same cycle as a step.
        for (int g = 0; g < 4 && (model_n % 4) != 3; g++) tick();
        mode_in   = 4'b1001;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        check("load_on_step_mode", 32'(dut.mode_q), 32'h9);
        ticks(6);

        // Strobe held high: mode tracks the input every cycle.
        mode_load = 1'b1;
        mode_in   = 4'b0001;
        tick();
        mode_in   = 4'b0100;
        tick();
        mode_in   = 4'b1111;
        tick();
        mode_load = 1'b0;
        check("held_load_mode", 32'(dut.mode_q), 32'hF);
        ticks(10);

        // Asynchronous 1 ns reset pulse mid-BREATHE.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_led",  32'(led), 32'd0);
        check("async_rst_duty", 32'(dut.duty_q), 32'd0);
        check("async_rst_cnt",  32'(dut.cnt_q), 32'd0);
        check("async_rst_mode", 32'(dut.mode_q), 32'hA);
        rst_n      = 1'b1;
        model_n    = 0;
        model_mode = 4'b1010;
        ticks(24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
